mem_port_sequencer: RTL and testbench

//   Shares the single memory port between instruction fetch (If*) and data load/store (D*).

---
 rtl/mem_port_sequencer.sv | 133 +++++++++++++
 tb/tb_mem_port_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_sequencer.sv
// Shares one memory port between instruction fetch and data load/store.
// Data wins by default; fetch is forced after STARVE_MAX back-to-back data grants.
module mem_port_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IfReq,
  input  logic [ADDR_W-1:0] IfAddr,
  output logic              IfGnt,
  output logic              IfValid,
  output logic [DATA_W-1:0] IfRdata,
  input  logic              DReq,
  input  logic              DWr,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWdata,
  output logic              DGnt,
  output logic              DValid,
  output logic [DATA_W-1:0] DRdata,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  output logic              Busy,
  output logic              Owner
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DONE, WR, WR_DONE} state_t;

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RD_LAT - 1);
  localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_MAX);

  state_t           state_reg;
  logic [LAT_W-1:0] lat_cnt_reg;
  logic [STV_W-1:0] starve_reg;
  logic [STV_W-1:0] starve_next;
  logic             fetch_forced;
  logic             pick_data;
  logic             pick_fetch;

  always_comb begin
    fetch_forced = IfReq && (starve_reg == STV_LIMIT);
    pick_data    = DReq && !fetch_forced;
    pick_fetch   = IfReq && !pick_data;
    starve_next  = starve_reg;
    if (pick_data) begin
      // Only data grants that bypass a waiting fetch count toward starvation.
      if (!IfReq)
        starve_next = '0;
      else if (starve_reg != STV_LIMIT)
        starve_next = starve_reg + 1'b1;
    end else if (pick_fetch) begin
      starve_next = '0;
    end
  end

  assign Busy = (state_reg != IDLE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= IDLE;
      lat_cnt_reg <= '0;
      starve_reg  <= '0;
      IfGnt       <= 1'b0;
      IfValid     <= 1'b0;
      IfRdata     <= '0;
      DGnt        <= 1'b0;
      DValid      <= 1'b0;
      DRdata      <= '0;
      MemAddr     <= '0;
      MemWr       <= 1'b0;
      MemWdata    <= '0;
      Owner       <= 1'b0;
    end else begin
      IfGnt   <= 1'b0;
      DGnt    <= 1'b0;
      IfValid <= 1'b0;
      DValid  <= 1'b0;
      MemWr   <= 1'b0;
      case (state_reg)
        IDLE: begin
          starve_reg <= starve_next;
          if (pick_data) begin
            MemAddr  <= DAddr;
            MemWdata <= DWdata;
            Owner    <= 1'b1;
            DGnt     <= 1'b1;
            if (DWr) begin
              MemWr     <= 1'b1;
              state_reg <= WR;
            end else begin
              lat_cnt_reg <= LAT_LAST;
              state_reg   <= RD_WAIT;
            end
          end else if (pick_fetch) begin
            MemAddr     <= IfAddr;
            Owner       <= 1'b0;
            IfGnt       <= 1'b1;
            lat_cnt_reg <= LAT_LAST;
            state_reg   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (lat_cnt_reg == '0) begin
            if (Owner) begin
              DRdata <= MemRdata;
              DValid <= 1'b1;
            end else begin
              IfRdata <= MemRdata;
              IfValid <= 1'b1;
            end
            state_reg <= RD_DONE;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 1'b1;
          end
        end
        RD_DONE: state_reg <= IDLE;
        WR: begin
          DValid    <= 1'b1;
          state_reg <= WR_DONE;
        end
        WR_DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer: fetch, load, store, starvation and reset cases.
module tb_mem_port_sequencer;

  logic        Clk;
  logic        Reset;
  logic        IfReq;
  logic [31:0] IfAddr;
  logic        IfGnt;
  logic        IfValid;
  logic [31:0] IfRdata;
  logic        DReq;
  logic        DWr;
  logic [31:0] DAddr;
  logic [31:0] DWdata;
  logic        DGnt;
  logic        DValid;
  logic [31:0] DRdata;
  logic [31:0] MemAddr;
  logic        MemWr;
  logic [31:0] MemWdata;
  logic [31:0] MemRdata;
  logic        Busy;
  logic        Owner;

  int checks = 0;
  int errors = 0;

  mem_port_sequencer #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2), .STARVE_MAX(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfGnt(IfGnt), .IfValid(IfValid), .IfRdata(IfRdata),
    .DReq(DReq), .DWr(DWr), .DAddr(DAddr), .DWdata(DWdata),
    .DGnt(DGnt), .DValid(DValid), .DRdata(DRdata),
    .MemAddr(MemAddr), .MemWr(MemWr), .MemWdata(MemWdata), .MemRdata(MemRdata),
    .Busy(Busy), .Owner(Owner)
  );

  // Memory model: one known word at 0x04, everything else derived from the address.
  assign MemRdata = (MemAddr == 32'h4) ? 32'hDEADBEEF : (MemAddr ^ 32'hA5A5_0000);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int runs[2];
    int run;
    int fetches;
    int cyc;
    int both_gnt;

    Reset = 1'b0; IfReq = 1'b0; IfAddr = '0;
    DReq = 1'b0; DWr = 1'b0; DAddr = '0; DWdata = '0;
    tick();
    chk("rst_busy", {31'b0, Busy}, 32'h0);
    chk("rst_memwr", {31'b0, MemWr}, 32'h0);
    chk("rst_memaddr", MemAddr, 32'h0);
    chk("rst_owner", {31'b0, Owner}, 32'h0);
    Reset = 1'b1;
    tick();
    chk("idle_busy", {31'b0, Busy}, 32'h0);
    chk("idle_gnt", {30'b0, IfGnt, DGnt}, 32'h0);

    // Fetch only from 0x04
    IfReq = 1'b1; IfAddr = 32'h4;
    tick();
    chk("f_ifgnt", {31'b0, IfGnt}, 32'h1);
    chk("f_busy_g", {31'b0, Busy}, 32'h1);
    chk("f_memaddr", MemAddr, 32'h4);
    chk("f_owner", {31'b0, Owner}, 32'h0);
    IfAddr = 32'h8;
    tick();
    chk("f_ifgnt_g1", {31'b0, IfGnt}, 32'h0);
    chk("f_ifvalid_g1", {31'b0, IfValid}, 32'h0);
    chk("f_memaddr_hold", MemAddr, 32'h4);
    tick();
    chk("f_ifvalid", {31'b0, IfValid}, 32'h1);
    chk("f_ifrdata", IfRdata, 32'hDEADBEEF);
    chk("f_busy_g2", {31'b0, Busy}, 32'h1);
    IfReq = 1'b0;
    tick();
    chk("f_idle", {30'b0, Busy, IfValid}, 32'h0);
    chk("f_ifrdata_hold", IfRdata, 32'hDEADBEEF);

    // Load and fetch requested together: data first
    IfReq = 1'b1; IfAddr = 32'h10; DReq = 1'b1; DWr = 1'b0; DAddr = 32'h40;
    tick();
    chk("ld_gnts", {30'b0, IfGnt, DGnt}, 32'h1);
    chk("ld_memaddr", MemAddr, 32'h40);
    chk("ld_owner", {31'b0, Owner}, 32'h1);
    tick();
    tick();
    chk("ld_dvalid", {31'b0, DValid}, 32'h1);
    chk("ld_drdata", DRdata, 32'hA5A50040);
    DReq = 1'b0;
    tick();
    chk("ld_gap", {30'b0, Busy, IfGnt}, 32'h0);
    tick();
    chk("ld_then_ifgnt", {31'b0, IfGnt}, 32'h1);
    chk("ld_then_memaddr", MemAddr, 32'h10);
    chk("ld_then_owner", {31'b0, Owner}, 32'h0);
    tick();
    tick();
    chk("ld_then_ifvalid", {31'b0, IfValid}, 32'h1);
    chk("ld_then_ifrdata", IfRdata, 32'hA5A50010);
    chk("ld_drdata_hold", DRdata, 32'hA5A50040);
    IfReq = 1'b0;
    tick();

    // Store to 0x80
    DReq = 1'b1; DWr = 1'b1; DAddr = 32'h80; DWdata = 32'h12345678;
    tick();
    chk("st_dgnt", {31'b0, DGnt}, 32'h1);
    chk("st_memwr", {31'b0, MemWr}, 32'h1);
    chk("st_memaddr", MemAddr, 32'h80);
    chk("st_memwdata", MemWdata, 32'h12345678);
    DWdata = 32'h0; DWr = 1'b0;
    tick();
    chk("st_memwr_off", {31'b0, MemWr}, 32'h0);
    chk("st_dvalid", {31'b0, DValid}, 32'h1);
    chk("st_wdata_hold", MemWdata, 32'h12345678);
    DReq = 1'b0;
    tick();
    chk("st_idle", {30'b0, Busy, DValid}, 32'h0);

    // Continuous stores with a fetch pending: 4 data grants, then fetch, twice
    IfReq = 1'b1; IfAddr = 32'h20; DReq = 1'b1; DWr = 1'b1; DAddr = 32'h84; DWdata = 32'h55;
    runs[0] = -1; runs[1] = -1; run = 0; fetches = 0; cyc = 0; both_gnt = 0;
    while (fetches < 2 && cyc < 200) begin
      tick();
      cyc++;
      if (IfGnt && DGnt) both_gnt++;
      if (DGnt) run++;
      if (IfGnt) begin
        runs[fetches] = run;
        run = 0;
        fetches++;
      end
    end
    chk("stv_fetches", fetches, 2);
    chk("stv_run0", runs[0], 4);
    chk("stv_run1", runs[1], 4);
    chk("stv_both_gnt", both_gnt, 0);
    DReq = 1'b0;
    tick();
    tick();
    chk("stv_ifvalid", {31'b0, IfValid}, 32'h1);
    chk("stv_ifrdata", IfRdata, 32'hA5A50020);
    IfReq = 1'b0;
    tick();

    // Reset during cycle G+1 of a fetch
    IfReq = 1'b1; IfAddr = 32'h4;
    tick();
    chk("rr_ifgnt", {31'b0, IfGnt}, 32'h1);
    tick();
    #2 Reset = 1'b0;
    #1;
    chk("rr_busy", {31'b0, Busy}, 32'h0);
    chk("rr_memaddr", MemAddr, 32'h0);
    chk("rr_ifrdata", IfRdata, 32'h0);
    chk("rr_drdata", DRdata, 32'h0);
    tick();
    chk("rr_no_ifvalid", {31'b0, IfValid}, 32'h0);
    tick();
    chk("rr_no_ifvalid2", {31'b0, IfValid}, 32'h0);
    Reset = 1'b1;
    tick();
    chk("rr_regrant", {31'b0, IfGnt}, 32'h1);
    tick();
    tick();
    chk("rr_ifvalid", {31'b0, IfValid}, 32'h1);
    chk("rr_ifrdata_new", IfRdata, 32'hDEADBEEF);
    IfReq = 1'b0;
    tick();

    // Reset while a store is in WR
    DReq = 1'b1; DWr = 1'b1; DAddr = 32'h88; DWdata = 32'hCAFE;
    tick();
    chk("rw_memwr_on", {31'b0, MemWr}, 32'h1);
    #2 Reset = 1'b0;
    #1;
    chk("rw_memwr_async", {31'b0, MemWr}, 32'h0);
    chk("rw_busy", {31'b0, Busy}, 32'h0);
    DReq = 1'b0; DWr = 1'b0;
    tick();
    chk("rw_no_dvalid", {31'b0, DValid}, 32'h0);
    Reset = 1'b1;
    tick();
    chk("rw_idle", {29'b0, Busy, DGnt, IfGnt}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
